// File: rtl/cpu_pkg.sv
// Definitions shared by the ALU and the M-extension sequencer: ALUCtrl codes,
// RV32M funct3 encodings and the sequencer state type.
package cpu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'h00;
  localparam logic [4:0] ALU_SUB  = 5'h01;
  localparam logic [4:0] ALU_SLTU = 5'h04;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER_A,
    S_ITER_B,
    S_FIX,
    S_DONE
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Sign handling for the sequencer: operand magnitudes on the way in and a
// 64-bit conditional two's-complement negate on the way out.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           a_signed,
  input  logic           b_signed,
  output logic [W-1:0]   a_mag,
  output logic [W-1:0]   b_mag,
  output logic           a_neg,
  output logic           b_neg,
  input  logic [2*W-1:0] val,
  input  logic           neg,
  output logic [2*W-1:0] val_fix
);

  assign a_neg   = a_signed & a[W-1];
  assign b_neg   = b_signed & b[W-1];
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;
  assign val_fix = neg ? -val : val;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer; each of the 32 rounds borrows the
// shared ALU for two cycles (ITER_A/ITER_B) and stalls while the grant is held back.
module muldiv_seq
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_req,
  input  logic            alu_gnt,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic [4:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_out
);

  muldiv_state_e   state;
  muldiv_op_e      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] hi, lo;       // {hi,lo}: product accumulator, or {rem, dividend/quotient}
  logic [XLEN-1:0] opb;          // multiplicand or divisor magnitude
  logic [XLEN-1:0] step_q;       // ITER_A result: partial sum or SLTU flag
  logic [4:0]      cnt;
  logic            neg_q;

  logic            is_mul, is_rem, a_signed, b_signed;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] madd, rem_sh;
  logic            cout, take;
  logic            div0, ovf, special;
  logic [XLEN-1:0] spec_res, fix_res;
  logic [2*XLEN-1:0] fix_in, fixed;

  assign is_mul   = ~op_q[2];
  assign is_rem   = op_q[1];
  assign a_signed = op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_signed = op_q inside {OP_MULH, OP_DIV, OP_REM};

  muldiv_sign_fix #(.W(XLEN)) u_sign_fix (
    .a        (a_q),
    .b        (b_q),
    .a_signed (a_signed),
    .b_signed (b_signed),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .a_neg    (a_neg),
    .b_neg    (b_neg),
    .val      (fix_in),
    .neg      (neg_q),
    .val_fix  (fixed)
  );

  // Multiply: add the multiplicand only when the current multiplier bit is set.
  assign madd   = lo[0] ? opb : '0;
  // Divide: {rem, dividend} shifted left by one, with the bit leaving rem as cout.
  assign rem_sh = {hi[XLEN-2:0], lo[XLEN-1]};
  assign cout   = hi[XLEN-1];
  assign take   = cout | ~step_q[0];

  assign div0     = (b_q == '0);
  assign ovf      = a_signed && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
  assign special  = ~is_mul & (div0 | ovf);
  assign spec_res = div0 ? (is_rem ? a_q : '1) : (is_rem ? '0 : a_q);

  assign fix_in  = is_mul ? {hi, lo} : {{XLEN{1'b0}}, (is_rem ? hi : lo)};
  assign fix_res = (is_mul && op_q != OP_MUL) ? fixed[2*XLEN-1:XLEN] : fixed[XLEN-1:0];

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    alu_rs1  = '0;
    alu_rs2  = '0;
    alu_ctrl = ALU_ADD;
    if (alu_req) begin
      case (state)
        S_ITER_A: begin
          alu_rs1  = is_mul ? hi : rem_sh;
          alu_rs2  = is_mul ? madd : opb;
          alu_ctrl = is_mul ? ALU_ADD : ALU_SLTU;
        end
        S_ITER_B: begin
          alu_rs1  = is_mul ? step_q : rem_sh;
          alu_rs2  = is_mul ? madd : opb;
          alu_ctrl = is_mul ? ALU_SLTU : ALU_SUB;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state and registered outputs update with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= OP_MUL;
      a_q     <= '0;
      b_q     <= '0;
      hi      <= '0;
      lo      <= '0;
      opb     <= '0;
      step_q  <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_req <= 1'b0;
      result  <= '0;
    end else if (flush && state != S_IDLE) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_req <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= muldiv_op_e'(op);
            a_q   <= rs1;
            b_q   <= rs2;
            busy  <= 1'b1;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          hi    <= '0;
          lo    <= a_mag;
          opb   <= b_mag;
          cnt   <= '0;
          neg_q <= (is_mul || !is_rem) ? (a_neg ^ b_neg) : a_neg;
          if (special) begin
            result <= spec_res;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            alu_req <= 1'b1;
            state   <= S_ITER_A;
          end
        end
        S_ITER_A: begin
          if (alu_gnt) begin
            step_q <= alu_out;
            state  <= S_ITER_B;
          end
        end
        S_ITER_B: begin
          if (alu_gnt) begin
            if (is_mul) begin
              {hi, lo} <= {alu_out[0], step_q, lo[XLEN-1:1]};
            end else begin
              hi <= take ? alu_out : rem_sh;
              lo <= {lo[XLEN-2:0], take};
            end
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              alu_req <= 1'b0;
              state   <= S_FIX;
            end else begin
              state <= S_ITER_A;
            end
          end
        end
        S_FIX: begin
          result <= fix_res;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: a scoreboard of expected result, done
// cycle and ALU-request count per operation, with a behavioural ALU alongside.
module tb_muldiv_seq;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, flush, alu_gnt;
  logic [2:0]  op;
  logic [31:0] rs1, rs2, alu_out;
  logic        busy, done, alu_req;
  logic [31:0] result, alu_rs1, alu_rs2;
  logic [4:0]  alu_ctrl;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          reqs;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .rs1      (rs1),
    .rs2      (rs2),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .alu_req  (alu_req),
    .alu_gnt  (alu_gnt),
    .alu_rs1  (alu_rs1),
    .alu_rs2  (alu_rs2),
    .alu_ctrl (alu_ctrl),
    .alu_out  (alu_out)
  );

  // Shared ALU; while the grant is withheld it serves EX and returns junk.
  always_comb begin
    alu_out = 32'hDEAD_BEEF;
    if (alu_gnt) begin
      case (alu_ctrl)
        ALU_ADD:  alu_out = alu_rs1 + alu_rs2;
        ALU_SUB:  alu_out = alu_rs1 - alu_rs2;
        ALU_SLTU: alu_out = {31'd0, alu_rs1 < alu_rs2};
        default:  alu_out = 32'hDEAD_BEEF;
      endcase
    end
  end

  function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb_, ub;
    logic [63:0] p;
    sa  = {{32{a[31]}}, a};
    sb_ = {{32{b[31]}}, b};
    ub  = {32'd0, b};
    case (o)
      3'b000: begin p = a * b;             return p[31:0];  end
      3'b001: begin p = sa * sb_;          return p[63:32]; end
      3'b010: begin p = sa * ub;           return p[63:32]; end
      3'b011: begin p = {32'd0, a} * ub;   return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Starts at a negedge in IDLE and returns at the negedge of the IDLE cycle after done.
  // stall: grant withheld in cycles 20..29; poke: second start in cycle 10;
  // with_flush: flush raised together with start.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_cyc, input int exp_req,
                        input string name, input bit stall, input bit poke, input bit with_flush);
    exp_t e;
    int   cyc, reqs;
    bit   got, idle_bad;
    e.res = exp_res; e.cyc = exp_cyc; e.reqs = exp_req; e.name = name;
    sb.push_back(e);
    op = o; rs1 = a; rs2 = b; start = 1'b1; flush = with_flush;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    cyc = 1; reqs = 0; got = 0; idle_bad = 0;
    while (!got && cyc < 300) begin
      alu_gnt = stall ? !(cyc >= 20 && cyc < 30) : 1'b1;
      if (poke && cyc == 10) begin
        op = 3'b101; rs1 = 32'd100; rs2 = 32'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (alu_req) begin
        reqs++;
        if (!(alu_ctrl inside {ALU_ADD, ALU_SUB, ALU_SLTU})) idle_bad = 1;
      end else if (alu_rs1 != 0 || alu_rs2 != 0 || alu_ctrl != 0) begin
        idle_bad = 1;
      end
      if (done) got = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0; alu_gnt = 1'b1;
    e = sb.pop_front();
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s timeout: no done within %0d cycles", e.name, cyc);
    end else begin
      n_cmp++;
      if (result !== e.res) begin
        n_bad++;
        $display("FAIL %s result: got %h expected %h", e.name, result, e.res);
      end
      if (cyc !== e.cyc) begin
        n_bad++;
        $display("FAIL %s done cycle: got %0d expected %0d", e.name, cyc, e.cyc);
      end
    end
    n_cmp++;
    if (reqs !== e.reqs) begin
      n_bad++;
      $display("FAIL %s alu_req cycles: got %0d expected %0d", e.name, reqs, e.reqs);
    end
    n_cmp++;
    if (idle_bad) begin
      n_bad++;
      $display("FAIL %s alu outputs: got illegal ctrl or nonzero idle operands expected clean", e.name);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== e.res) begin
      n_bad++;
      $display("FAIL %s after done: got busy=%b done=%b result=%h expected 0 0 %h",
               e.name, busy, done, result, e.res);
    end
    last_res = e.res;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; alu_gnt = 1'b1;
    op = 3'b000; rs1 = '0; rs2 = '0;
    #23;
    n_cmp++;
    if ({busy, done, alu_req} !== 3'b000 || result !== 0 || alu_rs1 !== 0 || alu_rs2 !== 0 || alu_ctrl !== 0) begin
      n_bad++;
      $display("FAIL reset: got busy=%b done=%b req=%b result=%h rs1=%h rs2=%h ctrl=%h expected all 0",
               busy, done, alu_req, result, alu_rs1, alu_rs2, alu_ctrl);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    run_op(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 67, 64, "mul",    0, 0, 0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 67, 64, "mulhu",  0, 0, 0);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 67, 64, "mulh",   0, 0, 0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 67, 64, "mulhsu", 0, 0, 0);
  endtask

  task automatic test_div();
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 67, 64, "div",  0, 0, 0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 67, 64, "rem",  0, 0, 0);
    run_op(3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 67, 64, "divu", 0, 0, 0);
  endtask

  task automatic test_special();
    run_op(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 2, 0, "divu_by0", 0, 0, 0);
    run_op(3'b110, 32'd5,         32'd0,         32'd5,         2, 0, "rem_by0",  0, 0, 0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0, "div_ovf",  0, 0, 0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2, 0, "rem_ovf",  0, 0, 0);
  endtask

  task automatic test_stall();
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 77, 74, "mul_stall", 1, 0, 0);
  endtask

  task automatic test_flush();
    int  cyc;
    bit  saw_done;
    op = 3'b000; rs1 = 32'd1234; rs2 = 32'd5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 1; cyc < 30; cyc++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || alu_req !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL flush cycle31: got busy=%b req=%b done=%b expected 0 0 0", busy, alu_req, done);
    end
    saw_done = 0;
    for (int i = 0; i < 80; i++) begin
      if (done) saw_done = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (saw_done || result !== last_res) begin
      n_bad++;
      $display("FAIL flush hold: got done_seen=%b result=%h expected 0 %h", saw_done, result, last_res);
    end
    run_op(3'b000, 32'd1234, 32'd5678, ref_md(3'b000, 32'd1234, 32'd5678), 67, 64, "after_flush", 0, 0, 0);
  endtask

  task automatic test_busy_start();
    run_op(3'b110, 32'd1000, 32'd7, 32'd6, 67, 64, "start_busy", 0, 1, 0);
    run_op(3'b100, 32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72, 67, 64, "start_flush", 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom();
      b = (i == 3) ? 32'd0 : $urandom() >> (i * 3);
      run_op(o, a, b, ref_md(o, a, b), is_special(o, a, b) ? 2 : 67,
             is_special(o, a, b) ? 0 : 64, $sformatf("b2b%0d_op%0d", i, o), 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_stall();
    test_flush();
    test_busy_start();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
